mio_read_mux: RTL

Parametrised successor to the memory/IO input selection path. It selects among NDEV memory-mapped device registers and main memory, or captures the bus value on a write. It sequences the memory access latency with a small state machine and registers the result into an MDR-bound output with a one-cycle ready pulse. It sits between the device registers, memory and the MDR load logic, and replaces the combinational input-select/MIO-select pair.

---
 rtl/mio_read_mux.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mio_read_mux.sv
// mio_read_mux: selects a device register, main memory or the bus value and
// registers it for the MDR, with a one-cycle ready pulse per accepted request.
//
// Handshake: REQ is sampled only while IDLE (BUSY=0). A request is accepted on
// the rising edge where the block is IDLE and REQ=1. SEL, WE, BUS and DEV_DATA
// are sampled at that same edge. R pulses for exactly one cycle (the DONE
// state) per accepted request. REQ seen while BUSY=1 is dropped, not queued.
module mio_read_mux #(
  parameter int WIDTH   = 16,
  parameter int NDEV    = 3,
  parameter int MEM_LAT = 4,
  localparam int SEL_W  = $clog2(NDEV + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ,
  input  logic                    WE,
  input  logic [SEL_W-1:0]        SEL,
  input  logic [NDEV*WIDTH-1:0]   DEV_DATA,
  input  logic [WIDTH-1:0]        MEM_DATA,
  input  logic [WIDTH-1:0]        BUS,
  output logic [WIDTH-1:0]        MDR_OUT,
  output logic                    R,
  output logic                    BUSY,
  output logic                    ERR,
  output logic [1:0]              dbg_state
);

  // Counter only has to hold MEM_LAT-1; keep at least one bit.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam bit MEM_ZERO = (MEM_LAT == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mdr_q, mdr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               err_q, err_n;
  logic [WIDTH-1:0]   dev_word;

  // Pick the addressed device register; only meaningful when SEL < NDEV.
  always_comb begin
    dev_word = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (SEL == SEL_W'(i)) dev_word = DEV_DATA[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-register values for the access sequencer.
  always_comb begin
    state_n = state;
    mdr_n   = mdr_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (REQ) begin
          err_n = 1'b0;
          if (WE) begin
            // Writes capture the bus and ignore SEL, even illegal values.
            mdr_n   = BUS;
            state_n = DONE;
          end else if (SEL < SEL_W'(NDEV)) begin
            mdr_n   = dev_word;
            state_n = DONE;
          end else if (SEL == SEL_W'(NDEV)) begin
            if (MEM_ZERO) begin
              mdr_n   = MEM_DATA;
              state_n = DONE;
            end else begin
              cnt_n   = CNT_INIT;
              state_n = WAIT;
            end
          end else begin
            mdr_n   = '0;
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          mdr_n   = MEM_DATA;
          state_n = DONE;
        end
      end
      DONE: begin
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: begin
        err_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      mdr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      mdr_q <= mdr_n;
      cnt_q <= cnt_n;
      err_q <= err_n;
    end
  end

  assign MDR_OUT   = mdr_q;
  assign R         = (state == DONE);
  assign BUSY      = (state != IDLE);
  assign ERR       = err_q;
  assign dbg_state = state;

endmodule
